// File: rtl/pc_counter_n.sv
// Parametrised program counter: clear, parallel load, up/down stepping by STEP
// against a run-time inclusive limit, with wrap or saturate on overflow.
module pc_counter_n #(
    parameter int WIDTH       = 16,
    parameter int STEP        = 1,
    parameter bit SATURATE    = 1'b0,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);

    logic [WIDTH:0]   sum;
    logic             up_ovf;
    logic             dn_unf;
    logic [WIDTH-1:0] step_val;
    logic             step_ovf;

    // One extra bit on the sum so an up step past the top of the range is
    // caught even when limit is all-ones.
    always_comb begin
        sum      = {1'b0, out} + {1'b0, STEP_V};
        up_ovf   = sum > {1'b0, limit};
        dn_unf   = out < STEP_V;
        step_val = '0;
        step_ovf = 1'b0;
        if (!down) begin
            step_ovf = up_ovf;
            if (up_ovf)
                step_val = SATURATE ? limit : '0;
            else
                step_val = sum[WIDTH-1:0];
        end else begin
            step_ovf = dn_unf;
            if (dn_unf)
                step_val = SATURATE ? '0 : limit;
            else
                step_val = out - STEP_V;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out        <= RESET_V;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            out        <= RESET_V;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (load) begin
            out <= in;
            ovf <= 1'b0;
        end else if (en) begin
            out <= step_val;
            ovf <= step_ovf;
            if (step_ovf)
                ovf_sticky <= 1'b1;
        end else begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_counter_n.sv
// Directed bench for pc_counter_n: four instances with different STEP/SATURATE
// share one control bus; each step checks the instances it targets.
module tb_pc_counter_n;

    logic        clk = 1'b0;
    logic        rst, clr, load, en, down;
    logic [15:0] in, limit;

    logic [15:0] a_out, b_out, c_out, d_out;
    logic        a_ovf, b_ovf, c_ovf, d_ovf;
    logic        a_st, b_st, c_st, d_st;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // a: program counter; b: modulo step 3; c: saturating step 3; d: step 2, reset value 7
    pc_counter_n #(.WIDTH(16), .STEP(1), .SATURATE(1'b0), .RESET_VALUE(0)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .in(in), .en(en), .down(down),
        .limit(limit), .out(a_out), .ovf(a_ovf), .ovf_sticky(a_st));
    pc_counter_n #(.WIDTH(16), .STEP(3), .SATURATE(1'b0), .RESET_VALUE(0)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .in(in), .en(en), .down(down),
        .limit(limit), .out(b_out), .ovf(b_ovf), .ovf_sticky(b_st));
    pc_counter_n #(.WIDTH(16), .STEP(3), .SATURATE(1'b1), .RESET_VALUE(0)) u_c (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .in(in), .en(en), .down(down),
        .limit(limit), .out(c_out), .ovf(c_ovf), .ovf_sticky(c_st));
    pc_counter_n #(.WIDTH(16), .STEP(2), .SATURATE(1'b0), .RESET_VALUE(7)) u_d (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .in(in), .en(en), .down(down),
        .limit(limit), .out(d_out), .ovf(d_ovf), .ovf_sticky(d_st));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; down = 1'b0;
        in = 16'h0000; limit = 16'hFFFF;
        #12;
        chk("rst_a_out", a_out, 16'h0000);
        chk("rst_a_ovf", {15'd0, a_ovf}, 16'h0000);
        chk("rst_d_out", d_out, 16'h0007);

        // async reset mid-cycle from 0x1234
        @(negedge clk); rst = 1'b0; load = 1'b1; in = 16'h1234;
        tick();
        chk("load_a_out", a_out, 16'h1234);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_a_out", a_out, 16'h0000);
        chk("async_a_ovf", {15'd0, a_ovf}, 16'h0000);
        chk("async_a_st", {15'd0, a_st}, 16'h0000);
        chk("async_d_out", d_out, 16'h0007);
        @(negedge clk); rst = 1'b0; en = 1'b1;
        tick();
        chk("post_rst_a_out", a_out, 16'h0001);

        // 16-bit wrap
        en = 1'b0; load = 1'b1; in = 16'hFFFE; limit = 16'hFFFF;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk("wrap1_out", a_out, 16'hFFFF);
        chk("wrap1_ovf", {15'd0, a_ovf}, 16'h0000);
        chk("wrap1_st", {15'd0, a_st}, 16'h0000);
        tick();
        chk("wrap2_out", a_out, 16'h0000);
        chk("wrap2_ovf", {15'd0, a_ovf}, 16'h0001);
        tick();
        chk("wrap3_out", a_out, 16'h0001);
        chk("wrap3_ovf", {15'd0, a_ovf}, 16'h0000);
        chk("wrap3_st", {15'd0, a_st}, 16'h0001);

        // modulo / saturate, STEP=3, limit=9
        en = 1'b0; clr = 1'b1; limit = 16'd9;
        tick();
        chk("clr_a_st", {15'd0, a_st}, 16'h0000);
        clr = 1'b0; en = 1'b1;
        tick(); chk("mod1_b", b_out, 16'd3); chk("mod1_c", c_out, 16'd3);
        tick(); chk("mod2_b", b_out, 16'd6); chk("mod2_c", c_out, 16'd6);
        tick(); chk("mod3_b", b_out, 16'd9); chk("mod3_c", c_out, 16'd9);
        chk("mod3_b_ovf", {15'd0, b_ovf}, 16'h0000);
        tick();
        chk("mod4_b", b_out, 16'd0);
        chk("mod4_b_ovf", {15'd0, b_ovf}, 16'h0001);
        chk("mod4_c", c_out, 16'd9);
        chk("mod4_c_ovf", {15'd0, c_ovf}, 16'h0001);
        tick();
        chk("mod5_b", b_out, 16'd3);
        chk("mod5_b_ovf", {15'd0, b_ovf}, 16'h0000);
        chk("mod5_c", c_out, 16'd9);
        chk("mod5_c_ovf", {15'd0, c_ovf}, 16'h0001);

        // down underflow, STEP=2, limit=0xFF
        en = 1'b0; load = 1'b1; in = 16'h0003; limit = 16'h00FF;
        tick();
        load = 1'b0; en = 1'b1; down = 1'b1;
        tick();
        chk("dn1_d", d_out, 16'h0001);
        chk("dn1_d_ovf", {15'd0, d_ovf}, 16'h0000);
        tick();
        chk("dn2_d", d_out, 16'h00FF);
        chk("dn2_d_ovf", {15'd0, d_ovf}, 16'h0001);
        chk("dn2_d_st", {15'd0, d_st}, 16'h0001);

        // priority: clr > load > en
        en = 1'b0; down = 1'b0; load = 1'b1; in = 16'h0050;
        tick();
        clr = 1'b1; load = 1'b1; en = 1'b1; in = 16'h0AAA;
        tick();
        chk("prio_a_out", a_out, 16'h0000);
        chk("prio_d_out", d_out, 16'h0007);
        chk("prio_d_st", {15'd0, d_st}, 16'h0000);
        clr = 1'b0;
        tick();
        chk("prio_load_a", a_out, 16'h0AAA);
        chk("prio_load_d", d_out, 16'h0AAA);

        // count above limit
        en = 1'b0; load = 1'b1; in = 16'h0020; limit = 16'h0010;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk("above_a_out", a_out, 16'h0000);
        chk("above_a_ovf", {15'd0, a_ovf}, 16'h0001);
        chk("above_c_out", c_out, 16'h0010);
        chk("above_c_ovf", {15'd0, c_ovf}, 16'h0001);

        // limit=0: every up step overflows to 0 in both modes
        limit = 16'h0000;
        tick();
        chk("lim0_a_out", a_out, 16'h0000);
        chk("lim0_a_ovf", {15'd0, a_ovf}, 16'h0001);
        chk("lim0_c_out", c_out, 16'h0000);

        // hold: ovf drops, count and sticky stay
        en = 1'b0;
        tick();
        chk("hold_a_out", a_out, 16'h0000);
        chk("hold_a_ovf", {15'd0, a_ovf}, 16'h0000);
        chk("hold_a_st", {15'd0, a_st}, 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_counter_n.md
Name: pc_counter_n

Overview:
- Parametrised program-counter/incrementer register, the sequential successor of the 16-bit ripple incrementer.
- Holds a WIDTH-bit count value and supports synchronous clear, parallel load, up/down stepping by a fixed STEP, a run-time upper limit, and a wrap or saturate mode.
- Used as the CPU program counter (WIDTH=16, STEP=1, limit=0xFFFF) and as a general loop/address counter in ROM/RAM sequencers.

Parameters:
- WIDTH, 16, bit width of count, load value and limit.
- STEP, 1, increment/decrement amount; legal range 1..2^WIDTH-1.
- SATURATE, 0, overflow mode: 0 = wrap, 1 = clamp at the bound.
- RESET_VALUE, 0, count value after rst and after clr.

Ports:
- clk  input  1  Clock. All state changes on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- clr  input  1  Synchronous clear to RESET_VALUE.
- load  input  1  Synchronous parallel load.
- in  input  WIDTH  Load value.
- en  input  1  Count enable.
- down  input  1  Count direction: 0 = up, 1 = down. Sampled only when en=1.
- limit  input  WIDTH  Inclusive upper bound of the count range. Sampled every cycle.
- out  output  WIDTH  Current count (registered).
- ovf  output  1  One-cycle pulse, registered. Asserted in the cycle after a step crossed a bound.
- ovf_sticky  output  1  Sticky overflow flag.

Behaviour:
- rst=1, asynchronous: out=RESET_VALUE, ovf=0, ovf_sticky=0 immediately. Holds while rst=1. Reset mid-count discards the step in progress.
- Synchronous priority per edge: clr > load > en > hold.
- clr=1: out<=RESET_VALUE, ovf<=0, ovf_sticky<=0.
- load=1 (clr=0): out<=in, ovf<=0, ovf_sticky unchanged. in is not range-checked against limit.
- en=1, down=0: compute sum = {1'b0,out}+STEP in WIDTH+1 bits.
  - If sum > {1'b0,limit}, the step overflows: SATURATE=0 gives out<=0; SATURATE=1 gives out<=limit.
  - Otherwise out<=sum[WIDTH-1:0].
- en=1, down=1: if out < STEP, the step underflows: SATURATE=0 gives out<=limit; SATURATE=1 gives out<=0. Otherwise out<=out-STEP.
- Overflow or underflow in either mode: ovf<=1, ovf_sticky<=1. Every other step or hold: ovf<=0.
- Saturate mode with out already at the bound: a further step still reports overflow. ovf pulses again and out stays at the bound.
- out above limit (after load, or after limit is lowered): the next up step overflows per mode. A down step is normal arithmetic, with no wrap check against limit.
- limit=0: up steps always overflow. Result is out=0 in both modes.
- Latency: one clock from the control inputs to out and ovf. No combinational path from inputs to outputs.
- en=0 with clr=0 and load=0: out, ovf_sticky hold; ovf<=0.
- WIDTH=16, STEP=1, limit=all-ones, en=1, down=0 reproduces in+1 with natural 16-bit wrap.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out=0x1234 -> out=0x0000, ovf=0, ovf_sticky=0 before the next edge. Release, en=1 -> out=0x0001 after 1 edge.
- Wrap up (WIDTH=16, STEP=1, SATURATE=0, limit=0xFFFF): load 0xFFFE, en=1 for 3 edges -> out=0xFFFF, 0x0000, 0x0001. ovf high only in the cycle out=0x0000. ovf_sticky=1 thereafter.
- Modulo/saturate (STEP=3, limit=9): from 0 up x4 -> 3, 6, 9, 0 with ovf on the 4th step (SATURATE=0). With SATURATE=1 -> 3, 6, 9, 9, ovf on the 4th step and again on the 5th.
- Down underflow (STEP=2, limit=0x00FF, SATURATE=0): load 0x0003, down=1, en x2 -> 0x0001, then 0x00FF with ovf=1.
- Priority: clr=load=en=1 with out=0x0050 -> out=RESET_VALUE, ovf_sticky=0. Then load=en=1, in=0x0AAA -> out=0x0AAA (no step applied).
- Out above limit: limit=0x0010, load 0x0020, up step -> out=0x0000 with ovf=1 (wrap) or out=0x0010 (saturate).
